sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Parametrised successor to the fixed two-way testbench/corelet SRAM mux.
- Arbitrates one single-port SRAM (active-low CEN/WEN) between NREQ corelet-side requestors and one testbench port.
- Corelet requestors use round-robin arbitration with a bounded burst hold; the testbench select overrides all requestors.
- Read data returns through a latency-matched tag pipeline, so each response is steered to its originating requestor, even across owner switches.

Parameters:
- NREQ, 2, number of corelet-side requestors (1..8).
- DW, 32, SRAM data width.
- AW, 7, SRAM address width.
- RD_LAT, 1, cycles from an accepted read to valid SRAM Q (1..4).
- MAX_BURST, 4, maximum consecutive grants to one requestor while others are waiting (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tb_sel  in  1  1 = testbench owns the SRAM; all corelet grants are forced to 0.
- tb_cen  in  1  testbench chip enable, active-low.
- tb_wen  in  1  testbench write enable, active-low.
- tb_a  in  AW  testbench address.
- tb_d  in  DW  testbench write data.
- tb_q  out  DW  read data to the testbench.
- tb_qvalid  out  1  tb_q is valid this cycle.
- req  in  NREQ  per-requestor access request.
- req_wen  in  NREQ  per-requestor write enable, active-low.
- req_a  in  NREQ*AW  packed addresses; requestor i uses slice i.
- req_d  in  NREQ*DW  packed write data.
- gnt  out  NREQ  one-hot grant, combinational, same cycle as the access.
- q  out  DW  read data to the corelet side.
- qvalid  out  1  q is valid this cycle.
- qid  out  $clog2(NREQ) (min 1)  index of the requestor that owns q.
- sram_cen  out  1  SRAM chip enable, active-low.
- sram_wen  out  1  SRAM write enable, active-low.
- sram_a  out  AW  SRAM address.
- sram_d  out  DW  SRAM write data.
- sram_q  in  DW  SRAM read data.

Behaviour:
- Reset (asynchronous): rr_ptr=0, burst_cnt=0, last_owner=0, read pipeline cleared.
- While reset is high: gnt=0, qvalid=0, tb_qvalid=0, qid=0, sram_cen=1, sram_wen=1.
- Testbench mode (tb_sel=1): sram_cen/wen/a/d = tb_cen/wen/a/d. gnt=0. Arbiter state frozen except burst_cnt, which clears to 0.
- Corelet mode (tb_sel=0), grant selection:
  - If no req is high: gnt=0, sram_cen=1.
  - Otherwise grant the first requestor with req high, searching from rr_ptr upward with wrap-around.
  - Hold rule: if last_owner is still requesting, burst_cnt<MAX_BURST-1, and the previous cycle granted last_owner, keep granting last_owner.
- Corelet mode, SRAM drive: sram_cen=0; sram_wen=req_wen[g]; sram_a/d = slice g, where g is the granted index.
- Grant bookkeeping, on each granted cycle:
  - last_owner<=g.
  - burst_cnt<=(g==last_owner && previous cycle granted) ? burst_cnt+1 : 0.
  - If the hold was released or the burst limit was hit, rr_ptr<=(g+1) mod NREQ.
  - When no grant is issued, burst_cnt<=0.
- A lone requestor with req held keeps the grant indefinitely; the burst limit applies only when another req is pending.
- Read tag pipeline:
  - An accepted read (sram_cen=0, sram_wen=1) pushes {valid=1, owner_is_tb, id} into an RD_LAT-deep shift register. Writes push valid=0.
  - At the tail: if valid && !owner_is_tb then qvalid=1, qid=id, q=sram_q. If valid && owner_is_tb then tb_qvalid=1, tb_q=sram_q.
  - q and tb_q are both continuously wired to sram_q; only the valid signals gate them.
- Owner switch: toggling tb_sel with reads in flight must not lose or misroute them. Each return goes to the owner recorded at issue time.
- Throughput: one access per cycle. Back-to-back reads from different requestors return in issue order, RD_LAT cycles each.
- Simultaneous read and return in the same cycle are independent; the shift register advances every cycle.
- Reset mid-burst or with reads in flight: all pending returns are discarded; no qvalid pulses after reset deasserts.

Decomposition:
- Shared package sram_arb_pkg: ID width function (clog2 with min 1), tag struct {valid, owner_is_tb, id}, default DW/AW constants shared with the SRAM wrapper.
- One sub-module: rr_arbiter (NREQ-wide round-robin pick from req and rr_ptr, returning a one-hot grant and its index).
- Read tag pipeline stays inline.

Test Plan:
- tb_sel=1, TB writes 0xDEADBEEF to addr 5, then reads addr 5 -> tb_qvalid=1 one cycle after the read (RD_LAT=1) with tb_q=0xDEADBEEF; gnt stays 0 and qvalid stays 0 throughout.
- tb_sel=0, req=2'b11 held, all reads, MAX_BURST=4 -> gnt sequence 01,01,01,01,10,10,10,10,01...; qid follows the same pattern delayed by RD_LAT.
- tb_sel=0, req=2'b10 only, held 10 cycles -> gnt=10 every cycle, burst limit not applied; when req[0] rises after 10 cycles, req1 keeps the grant until the end of the current burst window, then req0 is granted.
- RD_LAT=3: corelet read issued in cycle t, tb_sel raised in cycle t+1 with a TB read -> cycle t+3 gives qvalid=1 with the corelet data; cycle t+4 gives tb_qvalid=1; no cross-routing.
- Reset asserted asynchronously with 2 reads in flight -> sram_cen=1 and gnt=0 immediately; after deassert, no qvalid/tb_qvalid for RD_LAT cycles and rr_ptr=0 (req=11 -> gnt=01 first).
- Write then read same address on consecutive cycles from different requestors (req0 writes 0x12345678 to addr 9, req1 reads addr 9) -> qvalid with qid=1 and q=0x12345678.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter and its SRAM wrapper.
package sram_arb_pkg;

  // Default SRAM geometry used by the arbiter and the SRAM wrapper.
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 7;

  // Widest requestor index supported (NREQ up to 8).
  localparam int ID_MAX_W = 3;

  // Index width for n items: clog2(n), never narrower than one bit.
  function automatic int id_width(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // One entry of the read-return tag pipeline.
  typedef struct packed {
    logic                valid;
    logic                owner_is_tb;
    logic [ID_MAX_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requestor with req high, searching upward from
// i_ptr with wrap-around. Returns a one-hot grant plus its index.
module rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = id_width(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // Two descending passes, later assignment wins: the pass over indices at
  // or above the pointer overrides the wrapped pass below the pointer, and
  // the descending order leaves the lowest qualifying index in each pass.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (i_req[j] && (j < int'(i_ptr))) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
        o_any    = 1'b1;
      end
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (i_req[j] && (j >= int'(i_ptr))) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = IW'(j);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM (active-low CEN/WEN) between NREQ corelet
// requestors (round-robin with bounded burst hold) and a testbench port
// that overrides them. Read returns are steered by a latency-matched tag
// pipeline, so each response reaches the owner recorded at issue time.
// There is no valid/ready handshake: an access is accepted in the cycle it
// is granted (gnt high, or tb_sel high with tb_cen low), and a read returns
// exactly RD_LAT cycles later with a single-cycle qvalid/tb_qvalid pulse.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tb_sel,
  input  logic                      tb_cen,
  input  logic                      tb_wen,
  input  logic [AW-1:0]             tb_a,
  input  logic [DW-1:0]             tb_d,
  output logic [DW-1:0]             tb_q,
  output logic                      tb_qvalid,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_wen,
  input  logic [NREQ*AW-1:0]        req_a,
  input  logic [NREQ*DW-1:0]        req_d,
  output logic [NREQ-1:0]           gnt,
  output logic [DW-1:0]             q,
  output logic                      qvalid,
  output logic [id_width(NREQ)-1:0] qid,
  output logic                      sram_cen,
  output logic                      sram_wen,
  output logic [AW-1:0]             sram_a,
  output logic [DW-1:0]             sram_d,
  input  logic [DW-1:0]             sram_q
);

  localparam int IW = id_width(NREQ);
  localparam int CW = id_width(MAX_BURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NREQ - 1);

  // Arbiter state
  logic [IW-1:0] r_rr_ptr;
  logic [CW-1:0] r_burst_cnt;
  logic [IW-1:0] r_last_owner;
  logic          r_prev_gnt;     // previous cycle granted r_last_owner
  rd_tag_t       r_tag [RD_LAT];

  logic [NREQ-1:0] w_arb_gnt;
  logic [IW-1:0]   w_arb_idx;
  logic            w_arb_any;
  logic            w_hold;
  logic            w_any;
  logic [IW-1:0]   w_idx;
  logic            w_same;
  logic [CW-1:0]   w_cnt_next;
  logic [IW-1:0]   w_next_ptr;
  rd_tag_t         w_push;
  logic [AW-1:0]   w_req_a [NREQ];
  logic [DW-1:0]   w_req_d [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_req_a[i] = req_a[i*AW +: AW];
    assign w_req_d[i] = req_d[i*DW +: DW];
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  // The current owner keeps the SRAM while it still requests and its burst
  // window is not used up. Once the window closes the round-robin search
  // decides; a lone requestor simply wins it again and opens a new window.
  assign w_hold = !tb_sel && r_prev_gnt && req[r_last_owner] &&
                  (r_burst_cnt < BURST_LAST);
  assign w_idx  = w_hold ? r_last_owner : w_arb_idx;
  assign w_any  = !reset && !tb_sel && (w_hold || w_arb_any);
  assign w_same = r_prev_gnt && (w_idx == r_last_owner);

  // Burst counter wraps at the window end so windows repeat for a lone owner.
  assign w_cnt_next = !w_same ? '0 :
                      (r_burst_cnt == BURST_LAST) ? '0 : r_burst_cnt + CW'(1);
  assign w_next_ptr = (w_idx == LAST_IDX) ? '0 : w_idx + IW'(1);

  // One-hot grant for the cycle's corelet access.
  always_comb begin
    gnt = '0;
    if (w_any) begin
      if (w_hold) gnt[r_last_owner] = 1'b1;
      else        gnt = w_arb_gnt;
    end
  end

  // SRAM port mux: reset parks the SRAM, tb_sel passes the testbench through.
  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (reset) begin
      sram_cen = 1'b1;
    end else if (tb_sel) begin
      sram_cen = tb_cen;
      sram_wen = tb_wen;
      sram_a   = tb_a;
      sram_d   = tb_d;
    end else if (w_any) begin
      sram_cen = 1'b0;
      sram_wen = req_wen[w_idx];
      sram_a   = w_req_a[w_idx];
      sram_d   = w_req_d[w_idx];
    end
  end

  // Arbitration bookkeeping; testbench mode freezes it apart from the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr     <= '0;
      r_burst_cnt  <= '0;
      r_last_owner <= '0;
      r_prev_gnt   <= 1'b0;
    end else if (tb_sel) begin
      r_burst_cnt <= '0;
      r_prev_gnt  <= 1'b0;
    end else if (w_any) begin
      r_last_owner <= w_idx;
      r_burst_cnt  <= w_cnt_next;
      r_prev_gnt   <= 1'b1;
      if (!w_hold) r_rr_ptr <= w_next_ptr;
    end else begin
      r_burst_cnt <= '0;
      r_prev_gnt  <= 1'b0;
    end
  end

  // Tag describing this cycle's access; only reads carry a valid tag.
  always_comb begin
    w_push             = '0;
    w_push.valid       = !sram_cen && sram_wen;
    w_push.owner_is_tb = tb_sel;
    w_push.id          = tb_sel ? '0 : ID_MAX_W'(w_idx);
  end

  // Tag shift register advancing every cycle in lockstep with SRAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= w_push;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign qvalid    = r_tag[RD_LAT-1].valid && !r_tag[RD_LAT-1].owner_is_tb;
  assign tb_qvalid = r_tag[RD_LAT-1].valid &&  r_tag[RD_LAT-1].owner_is_tb;
  assign qid       = qvalid ? r_tag[RD_LAT-1].id[IW-1:0] : '0;
  assign q         = sram_q;
  assign tb_q      = sram_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: instance A uses RD_LAT=1, instance B
// RD_LAT=3; both share stimulus and each has its own behavioural SRAM.
module tb_sram_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 7;
  localparam int NREQ = 2;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic              tb_sel, tb_cen, tb_wen;
  logic [AW-1:0]     tb_a;
  logic [DW-1:0]     tb_d;
  logic [NREQ-1:0]   req, req_wen;
  logic [NREQ*AW-1:0] req_a;
  logic [NREQ*DW-1:0] req_d;

  logic [DW-1:0]   a_tb_q, a_q, a_sram_d, a_sram_q;
  logic            a_tb_qvalid, a_qvalid, a_sram_cen, a_sram_wen;
  logic [NREQ-1:0] a_gnt;
  logic [0:0]      a_qid;
  logic [AW-1:0]   a_sram_a;

  logic [DW-1:0]   b_tb_q, b_q, b_sram_d, b_sram_q;
  logic            b_tb_qvalid, b_qvalid, b_sram_cen, b_sram_wen;
  logic [NREQ-1:0] b_gnt;
  logic [0:0]      b_qid;
  logic [AW-1:0]   b_sram_a;

  int n_checks = 0;
  int n_fail = 0;

  sram_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .RD_LAT(1), .MAX_BURST(4)) u_a (
    .clk(clk), .reset(reset), .tb_sel(tb_sel), .tb_cen(tb_cen), .tb_wen(tb_wen),
    .tb_a(tb_a), .tb_d(tb_d), .tb_q(a_tb_q), .tb_qvalid(a_tb_qvalid),
    .req(req), .req_wen(req_wen), .req_a(req_a), .req_d(req_d),
    .gnt(a_gnt), .q(a_q), .qvalid(a_qvalid), .qid(a_qid),
    .sram_cen(a_sram_cen), .sram_wen(a_sram_wen), .sram_a(a_sram_a),
    .sram_d(a_sram_d), .sram_q(a_sram_q)
  );

  sram_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .RD_LAT(3), .MAX_BURST(4)) u_b (
    .clk(clk), .reset(reset), .tb_sel(tb_sel), .tb_cen(tb_cen), .tb_wen(tb_wen),
    .tb_a(tb_a), .tb_d(tb_d), .tb_q(b_tb_q), .tb_qvalid(b_tb_qvalid),
    .req(req), .req_wen(req_wen), .req_a(req_a), .req_d(req_d),
    .gnt(b_gnt), .q(b_q), .qvalid(b_qvalid), .qid(b_qid),
    .sram_cen(b_sram_cen), .sram_wen(b_sram_wen), .sram_a(b_sram_a),
    .sram_d(b_sram_d), .sram_q(b_sram_q)
  );

  // Behavioural SRAMs: A returns one cycle after a read, B three cycles.
  logic [DW-1:0] mem_a [0:127];
  logic [DW-1:0] mem_b [0:127];
  logic [DW-1:0] b_q1, b_q2, b_q3;

  always @(posedge clk) begin
    if (!a_sram_cen) begin
      if (!a_sram_wen) mem_a[a_sram_a] <= a_sram_d;
      else             a_sram_q <= mem_a[a_sram_a];
    end
  end

  always @(posedge clk) begin
    if (!b_sram_cen) begin
      if (!b_sram_wen) mem_b[b_sram_a] <= b_sram_d;
      else             b_q1 <= mem_b[b_sram_a];
    end
    b_q2 <= b_q1;
    b_q3 <= b_q2;
  end
  assign b_sram_q = b_q3;

  task automatic test_reset();
    #1;
    reset = 1'b1; tb_sel = 1'b0; req = 2'b11; req_wen = 2'b11;
    @(negedge clk); #1;
    n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", a_gnt); end
    n_checks++; if (a_sram_cen !== 1'b1) begin n_fail++; $display("FAIL reset_cen: got %b expected 1", a_sram_cen); end
    n_checks++; if (a_sram_wen !== 1'b1) begin n_fail++; $display("FAIL reset_wen: got %b expected 1", a_sram_wen); end
    n_checks++; if (a_qvalid !== 1'b0) begin n_fail++; $display("FAIL reset_qvalid: got %b expected 0", a_qvalid); end
    n_checks++; if (a_tb_qvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tb_qvalid: got %b expected 0", a_tb_qvalid); end
    n_checks++; if (a_qid !== 1'b0) begin n_fail++; $display("FAIL reset_qid: got %b expected 0", a_qid); end
    n_checks++; if (b_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt_b: got %b expected 00", b_gnt); end
    tb_sel = 1'b1; tb_cen = 1'b1; req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_tb_mode();
    @(negedge clk);
    tb_sel = 1'b1; req = 2'b11; req_wen = 2'b11;
    tb_cen = 1'b0; tb_wen = 1'b0; tb_a = 7'd5; tb_d = 32'hDEADBEEF;
    #1;
    n_checks++; if (a_sram_cen !== 1'b0) begin n_fail++; $display("FAIL tbw_cen: got %b expected 0", a_sram_cen); end
    n_checks++; if (a_sram_wen !== 1'b0) begin n_fail++; $display("FAIL tbw_wen: got %b expected 0", a_sram_wen); end
    n_checks++; if (a_sram_a !== 7'd5) begin n_fail++; $display("FAIL tbw_addr: got %0d expected 5", a_sram_a); end
    n_checks++; if (a_sram_d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL tbw_data: got %h expected deadbeef", a_sram_d); end
    n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL tbw_gnt: got %b expected 00", a_gnt); end
    @(negedge clk);
    tb_wen = 1'b1;
    #1;
    n_checks++; if (a_tb_qvalid !== 1'b0) begin n_fail++; $display("FAIL tbr_noret_write: got %b expected 0", a_tb_qvalid); end
    n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL tbr_gnt: got %b expected 00", a_gnt); end
    @(negedge clk);
    tb_cen = 1'b1;
    #1;
    n_checks++; if (a_tb_qvalid !== 1'b1) begin n_fail++; $display("FAIL tb_qvalid: got %b expected 1", a_tb_qvalid); end
    n_checks++; if (a_tb_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL tb_q: got %h expected deadbeef", a_tb_q); end
    n_checks++; if (a_qvalid !== 1'b0) begin n_fail++; $display("FAIL tb_mode_qvalid: got %b expected 0", a_qvalid); end
    n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL tb_mode_gnt: got %b expected 00", a_gnt); end
    // Preload the round-robin read addresses.
    @(negedge clk);
    tb_cen = 1'b0; tb_wen = 1'b0; tb_a = 7'd1; tb_d = 32'h11111111;
    #1;
    n_checks++; if (a_tb_qvalid !== 1'b0) begin n_fail++; $display("FAIL tb_qvalid_pulse: got %b expected 0", a_tb_qvalid); end
    @(negedge clk);
    tb_a = 7'd2; tb_d = 32'h22222222;
    @(negedge clk);
    tb_cen = 1'b1; req = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    logic [0:0] own [12];
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        tb_sel = 1'b0; req = 2'b11; req_wen = 2'b11; req_a = {7'd2, 7'd1};
      end
      #1;
      exp_g = (((k / 4) % 2) == 0) ? 2'b01 : 2'b10;
      own[k] = (exp_g == 2'b10) ? 1'b1 : 1'b0;
      n_checks++; if (a_gnt !== exp_g) begin n_fail++; $display("FAIL rr_gnt k=%0d: got %b expected %b", k, a_gnt, exp_g); end
      if (k == 0) begin
        n_checks++; if (a_qvalid !== 1'b0) begin n_fail++; $display("FAIL rr_qvalid0: got %b expected 0", a_qvalid); end
      end else begin
        n_checks++; if (a_qvalid !== 1'b1) begin n_fail++; $display("FAIL rr_qvalid k=%0d: got %b expected 1", k, a_qvalid); end
        n_checks++; if (a_qid !== own[k-1]) begin n_fail++; $display("FAIL rr_qid k=%0d: got %0d expected %0d", k, a_qid, own[k-1]); end
        n_checks++; if (a_q !== (own[k-1] ? 32'h22222222 : 32'h11111111)) begin n_fail++; $display("FAIL rr_q k=%0d: got %h", k, a_q); end
      end
      if (k >= 3) begin
        n_checks++; if (b_qvalid !== 1'b1) begin n_fail++; $display("FAIL rr_qvalid_b k=%0d: got %b expected 1", k, b_qvalid); end
        n_checks++; if (b_qid !== own[k-3]) begin n_fail++; $display("FAIL rr_qid_b k=%0d: got %0d expected %0d", k, b_qid, own[k-3]); end
      end
    end
    @(negedge clk);
    req = 2'b00;
    #1;
    n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL idle_gnt: got %b expected 00", a_gnt); end
    n_checks++; if (a_sram_cen !== 1'b1) begin n_fail++; $display("FAIL idle_cen: got %b expected 1", a_sram_cen); end
    n_checks++; if (a_qid !== 1'b0 || a_qvalid !== 1'b1) begin n_fail++; $display("FAIL idle_last_ret: got qvalid %b qid %0d expected 1 0", a_qvalid, a_qid); end
  endtask

  task automatic test_lone_requestor();
    logic [NREQ-1:0] exp_g;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k == 0)  req = 2'b10;
      if (k == 10) req = 2'b11;
      #1;
      exp_g = (k < 12) ? 2'b10 : 2'b01;
      n_checks++; if (a_gnt !== exp_g) begin n_fail++; $display("FAIL lone_gnt k=%0d: got %b expected %b", k, a_gnt, exp_g); end
    end
    @(negedge clk);
    req = 2'b00;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req = 2'b01; req_wen = 2'b10; req_a = {7'd9, 7'd9}; req_d = {32'h0, 32'h12345678};
    #1;
    n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got %b expected 01", a_gnt); end
    n_checks++; if (a_sram_wen !== 1'b0) begin n_fail++; $display("FAIL wr_wen: got %b expected 0", a_sram_wen); end
    n_checks++; if (a_sram_a !== 7'd9) begin n_fail++; $display("FAIL wr_addr: got %0d expected 9", a_sram_a); end
    n_checks++; if (a_sram_d !== 32'h12345678) begin n_fail++; $display("FAIL wr_data: got %h expected 12345678", a_sram_d); end
    @(negedge clk);
    req = 2'b10; req_wen = 2'b11;
    #1;
    n_checks++; if (a_gnt !== 2'b10) begin n_fail++; $display("FAIL rd_gnt: got %b expected 10", a_gnt); end
    n_checks++; if (a_sram_cen !== 1'b0 || a_sram_wen !== 1'b1) begin n_fail++; $display("FAIL rd_ctl: got cen %b wen %b expected 0 1", a_sram_cen, a_sram_wen); end
    n_checks++; if (a_qvalid !== 1'b0) begin n_fail++; $display("FAIL wr_noret: got %b expected 0", a_qvalid); end
    @(negedge clk);
    req = 2'b00;
    #1;
    n_checks++; if (a_qvalid !== 1'b1) begin n_fail++; $display("FAIL wrrd_qvalid: got %b expected 1", a_qvalid); end
    n_checks++; if (a_qid !== 1'b1) begin n_fail++; $display("FAIL wrrd_qid: got %0d expected 1", a_qid); end
    n_checks++; if (a_q !== 32'h12345678) begin n_fail++; $display("FAIL wrrd_q: got %h expected 12345678", a_q); end
  endtask

  task automatic test_owner_switch();
    repeat (3) @(negedge clk);
    @(negedge clk);
    tb_sel = 1'b0; req = 2'b01; req_wen = 2'b11; req_a = {7'd0, 7'd9};
    #1;
    n_checks++; if (b_gnt !== 2'b01) begin n_fail++; $display("FAIL sw_gnt: got %b expected 01", b_gnt); end
    @(negedge clk);
    tb_sel = 1'b1; req = 2'b00; tb_cen = 1'b0; tb_wen = 1'b1; tb_a = 7'd5;
    #1;
    n_checks++; if (b_gnt !== 2'b00) begin n_fail++; $display("FAIL sw_tb_gnt: got %b expected 00", b_gnt); end
    n_checks++; if (a_qvalid !== 1'b1 || a_qid !== 1'b0) begin n_fail++; $display("FAIL sw_a_ret: got qvalid %b qid %0d expected 1 0", a_qvalid, a_qid); end
    n_checks++; if (a_q !== 32'h12345678) begin n_fail++; $display("FAIL sw_a_q: got %h expected 12345678", a_q); end
    n_checks++; if (b_qvalid !== 1'b0) begin n_fail++; $display("FAIL sw_b_early: got %b expected 0", b_qvalid); end
    @(negedge clk);
    tb_cen = 1'b1;
    #1;
    n_checks++; if (a_tb_qvalid !== 1'b1 || a_qvalid !== 1'b0) begin n_fail++; $display("FAIL sw_a_tbret: got tb_qvalid %b qvalid %b expected 1 0", a_tb_qvalid, a_qvalid); end
    n_checks++; if (a_tb_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_a_tb_q: got %h expected deadbeef", a_tb_q); end
    n_checks++; if (b_qvalid !== 1'b0 || b_tb_qvalid !== 1'b0) begin n_fail++; $display("FAIL sw_b_t2: got qvalid %b tb_qvalid %b expected 0 0", b_qvalid, b_tb_qvalid); end
    @(negedge clk); #1;
    n_checks++; if (b_qvalid !== 1'b1 || b_tb_qvalid !== 1'b0) begin n_fail++; $display("FAIL sw_b_t3: got qvalid %b tb_qvalid %b expected 1 0", b_qvalid, b_tb_qvalid); end
    n_checks++; if (b_qid !== 1'b0) begin n_fail++; $display("FAIL sw_b_qid: got %0d expected 0", b_qid); end
    n_checks++; if (b_q !== 32'h12345678) begin n_fail++; $display("FAIL sw_b_q: got %h expected 12345678", b_q); end
    @(negedge clk); #1;
    n_checks++; if (b_tb_qvalid !== 1'b1 || b_qvalid !== 1'b0) begin n_fail++; $display("FAIL sw_b_t4: got tb_qvalid %b qvalid %b expected 1 0", b_tb_qvalid, b_qvalid); end
    n_checks++; if (b_tb_q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_b_tb_q: got %h expected deadbeef", b_tb_q); end
    @(negedge clk); #1;
    n_checks++; if (b_qvalid !== 1'b0 || b_tb_qvalid !== 1'b0) begin n_fail++; $display("FAIL sw_b_t5: got qvalid %b tb_qvalid %b expected 0 0", b_qvalid, b_tb_qvalid); end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    tb_sel = 1'b0; tb_cen = 1'b1; req = 2'b01; req_wen = 2'b11; req_a = {7'd0, 7'd9};
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (a_gnt !== 2'b00 || b_gnt !== 2'b00) begin n_fail++; $display("FAIL arst_gnt: got %b %b expected 00 00", a_gnt, b_gnt); end
    n_checks++; if (a_sram_cen !== 1'b1 || b_sram_cen !== 1'b1) begin n_fail++; $display("FAIL arst_cen: got %b %b expected 1 1", a_sram_cen, b_sram_cen); end
    n_checks++; if (a_qvalid !== 1'b0 || b_qvalid !== 1'b0) begin n_fail++; $display("FAIL arst_qvalid: got %b %b expected 0 0", a_qvalid, b_qvalid); end
    @(negedge clk);
    reset = 1'b0; req = 2'b00;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++; if (b_qvalid !== 1'b0 || b_tb_qvalid !== 1'b0 || a_qvalid !== 1'b0) begin n_fail++; $display("FAIL post_rst_ret k=%0d: got b %b %b a %b expected 0", k, b_qvalid, b_tb_qvalid, a_qvalid); end
    end
    @(negedge clk);
    req = 2'b11;
    #1;
    n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL post_rst_ptr: got %b expected 01", a_gnt); end
    @(negedge clk);
    req = 2'b00;
  endtask

  initial begin
    reset = 1'b1; tb_sel = 1'b0; tb_cen = 1'b1; tb_wen = 1'b1; tb_a = '0; tb_d = '0;
    req = '0; req_wen = '1; req_a = '0; req_d = '0;
    test_reset();
    test_tb_mode();
    test_round_robin();
    test_lone_requestor();
    test_write_read();
    test_owner_switch();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test sequence");
    $fatal(1);
  end

endmodule
